// File: rtl/mux_reg_arbiter.sv
// Four-way round-robin arbiter that owns one shared WIDTH-bit register.
// Define MUXREG_PARITY_EN to add the registered q_par output.
module mux_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wr_data,
  output logic [3:0]         gnt,
  output logic               ack,
  output logic               busy,
`ifdef MUXREG_PARITY_EN
  output logic               q_par,
`endif
  output logic [WIDTH-1:0]   q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nx;
  logic [1:0]       win;
  logic [1:0]       win_nx;
  logic [1:0]       pick;
  logic             found;
  logic [3:0]       hcnt;
  logic [3:0]       hcnt_nx;
  logic [3:0]       gnt_nx;
  logic             ack_nx;
  logic             commit;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] lane [4];

  // Split the packed write bus into per-requester lanes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i] = wr_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first set request at ptr, ptr+1, ... mod 4.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr + 2'(k)]) begin
        pick  = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    win_nx   = win;
    hcnt_nx  = hcnt;
    gnt_nx   = gnt;
    ack_nx   = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          win_nx   = pick;
          gnt_nx   = 4'b0001 << pick;
          hcnt_nx  = 4'(HOLD - 1);
        end
      end
      GRANT: begin
        if (!req[win]) begin
          state_nx = IDLE;
          gnt_nx   = 4'b0000;
          ptr_nx   = win + 2'd1;
        end else if (hcnt != 4'd0) begin
          hcnt_nx = hcnt - 4'd1;
        end else begin
          commit   = 1'b1;
          state_nx = ACK;
          gnt_nx   = 4'b0000;
          ack_nx   = 1'b1;
          ptr_nx   = win + 2'd1;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Only the commit edge samples the winner's lane.
  always_comb begin
    q_nx = commit ? lane[win] : q;
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      win   <= 2'd0;
      hcnt  <= 4'd0;
      gnt   <= 4'b0000;
      ack   <= 1'b0;
      q     <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      win   <= win_nx;
      hcnt  <= hcnt_nx;
      gnt   <= gnt_nx;
      ack   <= ack_nx;
      q     <= q_nx;
    end
  end

`ifdef MUXREG_PARITY_EN
  // Parity tracks q on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_par <= 1'b0;
    end else begin
      q_par <= ^q_nx;
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule
